// File: rtl/display_source_scheduler.sv
// display_source_scheduler
//
// Time-shares the 4-digit seven-segment display driver between four value
// sources. Enabled sources are shown round-robin for DWELL_CYCLES each; an
// alert request pre-empts the rotation and pins one source for ALERT_CYCLES,
// after which rotation resumes at the source that was interrupted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no source enabled, display blanked (num=0, disp_valid=0)
// ROTATE | showing src_sel, dwell counter runs unless hold=1
// ALERT  | alerted source pinned, alert counter runs every cycle
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   src_num      four packed 13-bit values, source i at [13*i+12:13*i]
//   src_en       rotation enable per source
//   alert_req    single-cycle pre-emption request per source
//   hold         freezes the rotation dwell counter
//   num          registered value for the display driver
//   src_sel      index of the source currently shown
//   disp_valid   a source is being shown
//   alert_active scheduler is in ALERT
//   switch_pulse first cycle of a new src_sel, or first cycle after IDLE
//
// All outputs come straight from flops; no input reaches an output
// combinationally.

module display_source_scheduler #(
  parameter int DWELL_CYCLES = 100000000,
  parameter int ALERT_CYCLES = 300000000,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [51:0] src_num,
  input  logic [3:0]  src_en,
  input  logic [3:0]  alert_req,
  input  logic        hold,
  output logic [12:0] num,
  output logic [1:0]  src_sel,
  output logic        disp_valid,
  output logic        alert_active,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    ALERT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       saved_q, saved_d;
  logic [1:0]       sel_q, sel_d;
  logic [12:0]      num_q;
  logic             valid_q, alert_q, pulse_q;
  logic [12:0]      src_val [4];

  // Lowest set bit; caller guarantees at least one bit is set.
  function automatic logic [1:0] lowest_set(input logic [3:0] bits);
    lowest_set = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bits[k]) lowest_set = 2'(k);
    end
  endfunction

  // First enabled source after cur, wrapping around and ending at cur itself.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur,
                                              input logic [3:0] en);
    logic [1:0] idx;
    logic       found;
    next_enabled = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!found && en[idx]) begin
        next_enabled = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_val[i] = src_num[13*i +: 13];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (|alert_req) begin
          state_d = ALERT;
          sel_d   = lowest_set(alert_req);
          saved_d = 2'd0;
          cnt_d   = '0;
        end else if (|src_en) begin
          state_d = ROTATE;
          sel_d   = lowest_set(src_en);
          cnt_d   = '0;
        end
      end

      ROTATE: begin
        if (|alert_req) begin
          // Save the index as shown now, even if the dwell expires this
          // cycle, so the interrupted source gets its turn back.
          state_d = ALERT;
          sel_d   = lowest_set(alert_req);
          saved_d = sel_q;
          cnt_d   = '0;
        end else if (!src_en[sel_q]) begin
          cnt_d = '0;
          if (|src_en) begin
            sel_d = next_enabled(sel_q, src_en);
          end else begin
            state_d = IDLE;
          end
        end else if (!hold) begin
          if (cnt_q == DWELL_LAST) begin
            sel_d = next_enabled(sel_q, src_en);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ALERT: begin
        if (|alert_req) begin
          sel_d = lowest_set(alert_req);
          cnt_d = '0;
        end else if (cnt_q == ALERT_LAST) begin
          cnt_d = '0;
          if (src_en[saved_q]) begin
            state_d = ROTATE;
            sel_d   = saved_q;
          end else if (|src_en) begin
            state_d = ROTATE;
            sel_d   = next_enabled(saved_q, src_en);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Entering IDLE leaves src_sel where it was, so no switch pulse fires;
  // leaving IDLE always pulses even if the index happens to match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      saved_q <= 2'd0;
      sel_q   <= 2'd0;
      num_q   <= '0;
      valid_q <= 1'b0;
      alert_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      saved_q <= saved_d;
      sel_q   <= sel_d;
      num_q   <= (state_d == IDLE) ? 13'd0 : src_val[sel_d];
      valid_q <= (state_d != IDLE);
      alert_q <= (state_d == ALERT);
      pulse_q <= (state_d != IDLE) && ((sel_d != sel_q) || (state_q == IDLE));
    end
  end

  assign num          = num_q;
  assign src_sel      = sel_q;
  assign disp_valid   = valid_q;
  assign alert_active = alert_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
module tb_display_source_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [51:0] src_num;
  logic [3:0]  src_en;
  logic [3:0]  alert_req;
  logic        hold;
  logic [12:0] num;
  logic [1:0]  src_sel;
  logic        disp_valid;
  logic        alert_active;
  logic        switch_pulse;

  int n_vec = 0;
  int n_bad = 0;

  display_source_scheduler #(
    .DWELL_CYCLES(4),
    .ALERT_CYCLES(6),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_num(src_num),
    .src_en(src_en),
    .alert_req(alert_req),
    .hold(hold),
    .num(num),
    .src_sel(src_sel),
    .disp_valid(disp_valid),
    .alert_active(alert_active),
    .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] nv(input int i);
    return 13'(100 * i + 7);
  endfunction

  // {num, src_sel, disp_valid, alert_active, switch_pulse}
  function automatic logic [17:0] pk(input int sel, input bit v,
                                     input bit a, input bit p);
    return {nv(sel), 2'(sel), v, a, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock, then compare the full output bundle.
  task automatic cyc(input string tag, input int sel, input bit a, input bit p);
    step();
    chk(tag, 32'({num, src_sel, disp_valid, alert_active, switch_pulse}),
        32'(pk(sel, 1'b1, a, p)));
  endtask

  // One clock, then expect a blanked display (src_sel is not checked in IDLE).
  task automatic cyc_idle(input string tag);
    step();
    chk(tag, 32'({num, disp_valid, alert_active, switch_pulse}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) src_num[13*i +: 13] = nv(i);
    rst_n = 1'b0; src_en = 4'b0; alert_req = 4'b0; hold = 1'b0;
    step();
    step();
    chk("reset", 32'({num, src_sel, disp_valid, alert_active, switch_pulse}), 32'd0);
    rst_n = 1'b1;
    cyc_idle("idle_no_en");

    // basic rotation 0,1,2,3,0
    src_en = 4'b1111;
    for (int k = 0; k <= 16; k++) cyc("rot", (k / 4) % 4, 1'b0, (k % 4) == 0);

    // sparse enable 1,3; drop 3 while shown; drop all
    src_en = 4'b1010;
    for (int k = 0; k <= 5; k++) cyc("sparse", ((k / 4) % 2 == 1) ? 3 : 1, 1'b0, (k % 4) == 0);
    src_en = 4'b0010;
    cyc("drop_cur", 1, 1'b0, 1'b1);
    cyc("drop_cur_hold", 1, 1'b0, 1'b0);
    src_en = 4'b0000;
    cyc_idle("drop_all");

    // hold freezes dwell
    src_en = 4'b1111;
    cyc("leave_idle", 0, 1'b0, 1'b1);
    cyc("pre_hold", 0, 1'b0, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) cyc("hold", 0, 1'b0, 1'b0);
    hold = 1'b0;
    cyc("post_hold1", 0, 1'b0, 1'b0);
    cyc("post_hold2", 0, 1'b0, 1'b0);
    cyc("post_hold_adv", 1, 1'b0, 1'b1);

    // alert at src_sel=2
    for (int k = 0; k < 3; k++) cyc("to_sel2", 1, 1'b0, 1'b0);
    cyc("sel2", 2, 1'b0, 1'b1);
    alert_req = 4'b1001;
    cyc("alert_in", 0, 1'b1, 1'b1);
    alert_req = 4'b0000;
    for (int k = 0; k < 5; k++) cyc("alert_hold", 0, 1'b1, 1'b0);
    cyc("alert_exit", 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc("fresh_dwell", 2, 1'b0, 1'b0);
    cyc("after_dwell", 3, 1'b0, 1'b1);

    // alert retarget at alert cycle 3
    alert_req = 4'b0001;
    cyc("alert2_in", 0, 1'b1, 1'b1);
    alert_req = 4'b0000;
    cyc("alert2_c2", 0, 1'b1, 1'b0);
    cyc("alert2_c3", 0, 1'b1, 1'b0);
    alert_req = 4'b0100;
    cyc("retarget", 2, 1'b1, 1'b1);
    alert_req = 4'b0000;
    for (int k = 0; k < 5; k++) cyc("retarget_hold", 2, 1'b1, 1'b0);
    cyc("alert2_exit", 3, 1'b0, 1'b1);

    // alert coinciding with dwell expiry at src_sel=1
    for (int k = 1; k <= 11; k++) cyc("to_sel1", (3 + k / 4) % 4, 1'b0, (k % 4) == 0);
    alert_req = 4'b1000;
    cyc("collide_in", 3, 1'b1, 1'b1);
    alert_req = 4'b0000;
    for (int k = 0; k < 5; k++) cyc("collide_hold", 3, 1'b1, 1'b0);
    cyc("collide_exit", 1, 1'b0, 1'b1);

    // alert with nothing enabled ends in IDLE
    src_en = 4'b0000;
    alert_req = 4'b0100;
    cyc("alert_noen_in", 2, 1'b1, 1'b1);
    alert_req = 4'b0000;
    for (int k = 0; k < 5; k++) cyc("alert_noen", 2, 1'b1, 1'b0);
    cyc_idle("alert_noen_exit");
    cyc_idle("alert_noen_idle");

    // reset mid-alert
    alert_req = 4'b0010;
    cyc("idle_alert_in", 1, 1'b1, 1'b1);
    alert_req = 4'b0000;
    cyc("idle_alert_c2", 1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid_alert_reset", 32'({num, src_sel, disp_valid, alert_active, switch_pulse}), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_reset_idle", 32'({num, src_sel, disp_valid, alert_active, switch_pulse}), 32'd0);
    end

    // single enabled source: dwell expiry keeps the index, no pulse
    src_en = 4'b0100;
    cyc("single_in", 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc("single_dwell", 2, 1'b0, 1'b0);
    cyc("single_wrap", 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Time-shares the 4-digit seven-segment display driver between four value sources.
- Rotates round-robin over enabled sources with a programmable dwell time.
- Supports pre-emptive alert requests that pin a source for a fixed hold time.
- Sits between the application datapath (counters, sensors, status) and the display driver's 13-bit num input.

Parameters:
DWELL_CYCLES, 100000000, cycles each source is shown during rotation (>=2)
ALERT_CYCLES, 300000000, cycles an alerted source is pinned (>=2)
CNT_W, 32, width of the shared dwell/alert counter; must hold max(DWELL_CYCLES, ALERT_CYCLES)-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
src_num  input  52  four packed 13-bit values, source i at [13*i+12:13*i]
src_en  input  4  source i participates in rotation when bit i is 1
alert_req  input  4  single-cycle pulse, source i requests pre-emption
hold  input  1  freezes the rotation dwell counter while 1
num  output  13  registered value routed to the display driver
src_sel  output  2  index of the source currently shown
disp_valid  output  1  1 when a source is shown; 0 in IDLE
alert_active  output  1  1 while in ALERT
switch_pulse  output  1  one-cycle pulse when src_sel changes, or when leaving IDLE

Behaviour:
- Reset (rst_n=0 at an edge):
  - state IDLE; num=0, src_sel=0, disp_valid=0, alert_active=0, switch_pulse=0.
  - Counter=0, saved rotation index=0.
  - Reset mid-rotation or mid-alert aborts immediately; there is no residual alert.
- Output registering:
  - At every edge, src_sel<=next_sel and num<=src_num slice[next_sel].
  - num is therefore always aligned with src_sel and lags live source data by 1 cycle.
  - In IDLE, num<=0.
- next_enabled(i): first set src_en bit scanning i+1, i+2, i+3, i (mod 4). Returns i itself if only bit i is set.
- IDLE:
  - Any src_en bit set -> next cycle ROTATE, src_sel=lowest set index, counter=0.
  - On that transition: disp_valid=1, switch_pulse=1.
- ROTATE:
  - Counter increments when hold=0 and holds when hold=1.
  - Counter==DWELL_CYCLES-1 with hold=0:
    - src_sel<=next_enabled(src_sel), counter<=0.
    - switch_pulse=1 only if the index changed.
  - Current src_en[src_sel] deasserted:
    - Switch next cycle to next_enabled(src_sel), counter=0, regardless of hold.
    - If no bits are set, go to IDLE, disp_valid=0.
- Alert entry (from IDLE or ROTATE):
  - Any alert_req bit in cycle t -> at t+1 state ALERT, src_sel=lowest set alert bit.
  - alert_active=1, counter=0, disp_valid=1.
  - Saved rotation index = current src_sel (0 if entered from IDLE).
  - src_en and hold are ignored for the alerted source.
- ALERT:
  - Counter increments every cycle; hold has no effect.
  - A new alert_req re-targets to the lowest set bit and restarts the counter at 0. The saved index is unchanged.
  - Counter==ALERT_CYCLES-1 -> alert_active=0, counter=0.
  - Exit target:
    - ROTATE at the saved index if src_en[saved] is 1.
    - Otherwise ROTATE at next_enabled(saved) if any src_en bit is set.
    - Otherwise IDLE.
- Priority in one cycle: reset > alert_req > src_en drop > dwell expiry. An alert coinciding with dwell expiry saves the un-advanced index.
- switch_pulse is registered and high for exactly the first cycle a new src_sel is visible.
- No combinational path from inputs to outputs.

Test Plan:
- Basic rotation. DWELL_CYCLES=4, src_en=4'b1111, src_num={13'd3,13'd2,13'd1,13'd0}.
  -> src_sel cycles 0,1,2,3,0 every 4 cycles; num tracks 0,1,2,3; switch_pulse once per change.
- Sparse enable. src_en=4'b1010.
  -> rotation alternates 1,3; src_en to 4'b0010 while showing 3 -> src_sel=1 next cycle with switch_pulse=1.
  -> src_en to 0 -> IDLE, num=0, disp_valid=0.
- Hold. hold=1 for 10 cycles mid-dwell.
  -> src_sel frozen; after release, the remaining dwell count completes and then advances.
- Alert. ALERT_CYCLES=6, rotation at src_sel=2, alert_req=4'b1001 pulse.
  -> next cycle src_sel=0, alert_active=1 for 6 cycles, then src_sel=2 with a fresh full dwell.
  -> A second alert_req=4'b0100 at alert cycle 3 -> src_sel=2 and the 6-cycle timer restarts.
- Collisions. alert_req coinciding with dwell expiry at src_sel=1 -> ALERT; on exit src_sel returns to 1.
  -> Alert with src_en=0 -> alerted source shown, then IDLE.
- Reset mid-alert. rst_n=0 for 1 cycle during ALERT.
  -> all outputs 0 the next cycle; IDLE until src_en is set.
